// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display controller.
package seg7_pkg;

    // Scan controller states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    // All segments off (active-low bus)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for BCD digits 0..9
    localparam logic [6:0] DIGIT_PATTERNS [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; non-BCD codes render as blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    // Table lookup for 0..9, everything else dark
    always_comb begin
        seg_n = SEG_BLANK;
        if (code < 4'd10) begin
            seg_n = DIGIT_PATTERNS[code];
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a shared active-low seven-segment bus.
// Each digit slot starts with a dark blanking interval, and the displayed
// value is swapped only at frame start so a frame never mixes old and new digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 12500,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      lz_suppress,
    output logic                      load_ack,
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     dig_en_n,
    output logic                      frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST       = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

    logic [1:0]              state;
    logic [1:0]              state_nx;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nx;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nx;
    logic                    transfer;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pending_valid;
    logic [3:0]              nibble_sel;
    logic                    blank_sel;
    logic                    lead_zero;
    logic [6:0]              dec_seg;

    // Next-state logic; transfer marks entry to BLANK of digit 0 (frame start)
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        transfer = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    transfer = 1'b1;
                end
                BLANK: begin
                    cnt_nx = cnt + CW'(1);
                    if (cnt == CNT_BLANK_LAST) begin
                        state_nx = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nx   = '0;
                            transfer = 1'b1;
                        end else begin
                            idx_nx = idx + IW'(1);
                        end
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Scan state, digit index and slot counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // Pending/active digit registers; a load landing on frame start bypasses pending
    always_ff @(posedge clk) begin
        if (rst) begin
            pending       <= '0;
            active        <= '0;
            pending_valid <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            load_ack <= load;
            if (load) begin
                pending <= digits_in;
            end
            if (transfer) begin
                pending_valid <= 1'b0;
                if (load) begin
                    active <= digits_in;
                end else if (pending_valid) begin
                    active <= pending;
                end
            end else if (load) begin
                pending_valid <= 1'b1;
            end
        end
    end

    // Select the nibble for the upcoming digit and decide leading-zero blanking
    always_comb begin
        nibble_sel = '0;
        blank_sel  = 1'b0;
        lead_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero = lead_zero && (active[i*4 +: 4] == 4'd0);
            if (idx_nx == IW'(i)) begin
                nibble_sel = active[i*4 +: 4];
                blank_sel  = lz_suppress && lead_zero && (i != 0);
            end
        end
    end

    seg7_decode u_decode (
        .code  (nibble_sel),
        .seg_n (dec_seg)
    );

    // Registered pin drivers, derived from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n      <= SEG_BLANK;
            dig_en_n   <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= SEG_BLANK;
            dig_en_n   <= '1;
            frame_done <= 1'b0;
            if (state_nx == SHOW) begin
                seg_n      <= blank_sel ? SEG_BLANK : dec_seg;
                dig_en_n   <= ~(NUM_DIGITS'(1) << idx_nx);
                frame_done <= (idx_nx == IDX_LAST) && (cnt_nx == CNT_LAST);
            end
        end
    end

endmodule
